// File: rtl/imem_loader.sv
// Instruction memory with a length-prefixed byte-stream program loader and a
// registered fetch port. Fetch latency is 1 cycle. Writes land on the edge that
// accepts a word's last byte.
// Backpressure: ld_ready is high only in HDR_HI/HDR_LO/DATA. Fetches while busy are dropped.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   fetch_en, fetch_addr          fetch request (honoured in IDLE only)
//   instr, instr_valid            registered fetch result (0 / invalid otherwise)
//   ld_start, ld_base             start a load at ld_base (sampled in IDLE)
//   ld_valid, ld_data, ld_ready   byte stream: count_hi, count_lo, N words MSB first
//   busy, load_done, load_err     status: not-IDLE, end-of-load pulse, sticky drop flag
//   words_loaded                  words written by the current or last load
module imem_loader #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 13,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BPW   = DATA_W / 8;
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WA_W  = ADDR_W + 16;
    localparam logic [WA_W-1:0] LAST_ADDR = WA_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [ADDR_W-1:0]   r_base;
    logic [15:0]         r_count;
    logic [15:0]         r_idx;
    logic [BC_W-1:0]     r_byte_cnt;
    logic [DATA_W-1:0]   r_word;
    logic [15:0]         r_words_loaded;
    logic                r_load_err;
    logic [DATA_W-1:0]   r_instr;
    logic                r_instr_valid;

    logic                w_acc;
    logic                w_last_byte;
    logic                w_word_done;
    logic [DATA_W-1:0]   w_word;
    logic [WA_W-1:0]     w_abs_addr;
    logic                w_in_range;
    logic [15:0]         w_count_full;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_waddr;
    logic [DATA_W-1:0]   w_mem_wdat;
    logic                w_fetch;

    assign ld_ready     = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_DATA);
    assign busy         = (r_state != S_IDLE);
    assign load_done    = (r_state == S_DONE);
    assign load_err     = r_load_err;
    assign words_loaded = r_words_loaded;
    assign instr        = r_instr;
    assign instr_valid  = r_instr_valid;

    assign w_acc        = ld_valid && ld_ready;
    assign w_last_byte  = (r_byte_cnt == BC_W'(BPW - 1));
    assign w_word_done  = (r_state == S_DATA) && w_acc && w_last_byte;
    // Shift the incoming byte in at the bottom; the oldest byte ends up as MSB.
    assign w_word       = DATA_W'({r_word, ld_data});
    // Target address is formed wide so an out-of-range word is detected, not wrapped.
    assign w_abs_addr   = WA_W'(r_base) + WA_W'(r_idx);
    assign w_in_range   = (w_abs_addr <= LAST_ADDR);
    assign w_count_full = {r_count[15:8], ld_data};
    assign w_fetch      = (r_state == S_IDLE) && fetch_en;

    // Single write port shared by the clear sweep and the loader.
    assign w_mem_we    = rst && ((r_state == S_CLEAR) || (w_word_done && w_in_range));
    assign w_mem_waddr = (r_state == S_CLEAR) ? r_clr_ptr : w_abs_addr[ADDR_W-1:0];
    assign w_mem_wdat  = (r_state == S_CLEAR) ? '0 : w_word;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= CLEAR_ON_RST ? S_CLEAR : S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR:  if (r_clr_ptr == ADDR_W'(DEPTH - 1)) w_state_nxt = S_IDLE;
            S_IDLE:   if (ld_start) w_state_nxt = S_HDR_HI;
            S_HDR_HI: if (w_acc) w_state_nxt = S_HDR_LO;
            S_HDR_LO: if (w_acc) w_state_nxt = (w_count_full == 16'd0) ? S_DONE : S_DATA;
            S_DATA:   if (w_word_done && ((r_idx + 16'd1) == r_count)) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clr_ptr      <= '0;
            r_base         <= '0;
            r_count        <= '0;
            r_idx          <= '0;
            r_byte_cnt     <= '0;
            r_word         <= '0;
            r_words_loaded <= '0;
            r_load_err     <= 1'b0;
            r_instr        <= '0;
            r_instr_valid  <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch;
            r_instr       <= w_fetch ? r_mem[fetch_addr] : '0;

            case (r_state)
                S_CLEAR: r_clr_ptr <= r_clr_ptr + 1'b1;
                S_IDLE: begin
                    if (ld_start) begin
                        r_base         <= ld_base;
                        r_count        <= '0;
                        r_idx          <= '0;
                        r_byte_cnt     <= '0;
                        r_word         <= '0;
                        r_words_loaded <= '0;
                        r_load_err     <= 1'b0;
                    end
                end
                S_HDR_HI: if (w_acc) r_count[15:8] <= ld_data;
                S_HDR_LO: if (w_acc) r_count[7:0]  <= ld_data;
                S_DATA: begin
                    if (w_acc) begin
                        if (w_last_byte) begin
                            r_byte_cnt <= '0;
                            r_word     <= '0;
                            r_idx      <= r_idx + 16'd1;
                            if (w_in_range) begin
                                r_words_loaded <= r_words_loaded + 16'd1;
                            end else begin
                                r_load_err <= 1'b1;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_word     <= w_word;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, sel;
    logic        fetch_en, ld_start, ld_valid;
    logic [3:0]  fetch_addr, ld_base;
    logic [7:0]  ld_data;

    logic [15:0] a_instr, b_instr, a_wl, b_wl;
    logic        a_iv, b_iv, a_rdy, b_rdy, a_busy, b_busy, a_done, b_done, a_err, b_err;

    logic [15:0] m_instr, m_wl;
    logic        m_iv, m_rdy, m_busy, m_done, m_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_mem [16];
    logic [15:0] img [$];

    always #5 clk = ~clk;

    imem_loader #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RST(1'b1)) u_dut_a (
        .clk(clk), .rst(rst_a), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .instr(a_instr), .instr_valid(a_iv), .ld_start(ld_start), .ld_base(ld_base),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(a_rdy), .busy(a_busy),
        .load_done(a_done), .load_err(a_err), .words_loaded(a_wl)
    );

    imem_loader #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RST(1'b0)) u_dut_b (
        .clk(clk), .rst(rst_b), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .instr(b_instr), .instr_valid(b_iv), .ld_start(ld_start), .ld_base(ld_base),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(b_rdy), .busy(b_busy),
        .load_done(b_done), .load_err(b_err), .words_loaded(b_wl)
    );

    assign m_instr = sel ? b_instr : a_instr;
    assign m_iv    = sel ? b_iv    : a_iv;
    assign m_rdy   = sel ? b_rdy   : a_rdy;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_err   = sel ? b_err   : a_err;
    assign m_wl    = sel ? b_wl    : a_wl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, check the reset values, then release.
    task automatic reset_sel();
        fetch_en = 0; ld_start = 0; ld_valid = 0;
        if (sel) rst_b = 0; else rst_a = 0;
        tick(); tick();
        chk("rst_instr_valid", m_iv, 0);
        chk("rst_instr", m_instr, 0);
        chk("rst_load_done", m_done, 0);
        chk("rst_load_err", m_err, 0);
        chk("rst_words_loaded", m_wl, 0);
        chk("rst_ld_ready", m_rdy, 0);
        if (sel) rst_b = 1; else rst_a = 1;
    endtask

    task automatic wait_clear();
        int n = 0;
        while (m_busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("clear_busy_cycles", n, 16);
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0;
    endtask

    task automatic fetch_sweep();
        fetch_en = 1;
        for (int a = 0; a < 16; a++) begin
            fetch_addr = a[3:0];
            tick();
            chk($sformatf("fetch_valid[%0d]", a), m_iv, 1);
            chk($sformatf("fetch_data[%0d]", a), m_instr, model_mem[a]);
        end
        fetch_en = 0;
        tick();
        chk("fetch_idle_valid", m_iv, 0);
        chk("fetch_idle_instr", m_instr, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit fchk);
        for (int g = 0; g < gap; g++) begin
            ld_valid = 0;
            tick();
            chk("ready_in_gap", m_rdy, 1);
        end
        chk("ready_at_byte", m_rdy, 1);
        ld_valid = 1;
        ld_data  = b;
        tick();
        ld_valid = 0;
        if (fchk) begin
            chk("busy_fetch_valid", m_iv, 0);
            chk("busy_fetch_instr", m_instr, 0);
        end
    endtask

    function automatic int pick_gap(input int gap);
        return (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    endfunction

    // Loads img[] at base; gap<0 picks random idle cycles before each byte.
    task automatic load(input int base, input int gap, input bit fchk);
        int n = img.size();
        int exp_wl = 0;
        bit exp_err = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i <= 15) begin
                model_mem[base + i] = img[i];
                exp_wl++;
            end else begin
                exp_err = 1;
            end
        end
        ld_start = 1;
        ld_base  = base[3:0];
        tick();
        ld_start = 0;
        chk("start_busy", m_busy, 1);
        chk("start_ready", m_rdy, 1);
        chk("start_err_cleared", m_err, 0);
        chk("start_wl_cleared", m_wl, 0);
        if (fchk) begin
            fetch_en   = 1;
            fetch_addr = 4'($urandom);
        end
        send_byte(8'(n >> 8), pick_gap(gap), fchk);
        send_byte(8'(n), pick_gap(gap), fchk);
        for (int i = 0; i < n; i++) begin
            send_byte(img[i][15:8], pick_gap(gap), fchk);
            send_byte(img[i][7:0], pick_gap(gap), fchk);
        end
        chk("done_pulse", m_done, 1);
        chk("done_busy", m_busy, 1);
        tick();
        fetch_en = 0;
        chk("done_single", m_done, 0);
        chk("idle_busy", m_busy, 0);
        chk("words_loaded", m_wl, exp_wl);
        chk("load_err", m_err, exp_err);
    endtask

    // Header announcing 3 words, then exactly one word 0x1122 at base 0.
    task automatic partial_load();
        ld_start = 1;
        ld_base  = 4'd0;
        tick();
        ld_start = 0;
        send_byte(8'h00, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        chk("partial_busy", m_busy, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; rst_a = 0; rst_b = 0;
        fetch_en = 0; fetch_addr = 0; ld_start = 0; ld_base = 0; ld_valid = 0; ld_data = 0;

        reset_sel();
        chk("rst_busy_clear", m_busy, 1);
        wait_clear();
        fetch_sweep();

        img = '{16'h9901, 16'h9982, 16'h09C0};
        load(0, 0, 0);
        fetch_en = 1; fetch_addr = 4'd1;
        tick();
        fetch_en = 0;
        chk("fetch_addr1", m_instr, 16'h9982);
        fetch_sweep();

        for (int i = 0; i < 3; i++) model_mem[i] = 16'h0;
        load(0, 3, 0);
        fetch_sweep();

        img = '{16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2};
        load(14, 0, 0);
        fetch_sweep();

        img = {};
        load(5, 0, 1);
        fetch_sweep();

        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(0, 5);
            img = {};
            for (int i = 0; i < n; i++) img.push_back(16'($urandom));
            load($urandom_range(0, 15), -1, 1'($urandom_range(0, 1)));
            fetch_sweep();
        end

        partial_load();
        reset_sel();
        chk("midload_rst_busy", m_busy, 1);
        wait_clear();
        fetch_sweep();

        rst_a = 0;
        sel   = 1;
        reset_sel();
        partial_load();
        reset_sel();
        tick();
        chk("noclr_rst_idle", m_busy, 0);
        fetch_en = 1; fetch_addr = 4'd0;
        tick();
        fetch_en = 0;
        chk("noclr_keep_valid", m_iv, 1);
        chk("noclr_keep_word", m_instr, 16'h1122);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
